// File: rtl/burst_data_gen_if.sv
// Trigger/length inputs and data/valid outputs of the burst pattern generator.
interface burst_data_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  data_gen_in;
  logic [7:0]            data_gen_num_in;
  logic [DATA_WIDTH-1:0] data_gen_o;
  logic                  data_gen_valid_o;

  modport master (
    input  data_gen_in,
    input  data_gen_num_in,
    output data_gen_o,
    output data_gen_valid_o
  );

  modport slave (
    output data_gen_in,
    output data_gen_num_in,
    input  data_gen_o,
    input  data_gen_valid_o
  );
endinterface

// File: rtl/burst_data_gen.sv
// Test-pattern source: a rising trigger edge emits N+1 incrementing words, one per cycle.
// Latency 1 cycle from the sampling edge; no backpressure, edges during a burst are dropped.
module burst_data_gen #(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] START_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0] STEP        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  burst_data_gen_if.master  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_n;
  logic                  trig_d;
  logic                  start;
  logic [7:0]            num_q, num_n;
  logic [8:0]            cnt, cnt_n;
  logic [DATA_WIDTH-1:0] acc, acc_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  vld_q, vld_n;

  assign start = bus.data_gen_in & ~trig_d;

  // trig_d resets high so a trigger already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      trig_d <= 1'b1;
      num_q  <= '0;
      cnt    <= '0;
      acc    <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_n;
      trig_d <= bus.data_gen_in;
      num_q  <= num_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      data_q <= data_n;
      vld_q  <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    num_n   = num_q;
    cnt_n   = cnt;
    acc_n   = acc;
    data_n  = '0;
    vld_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          num_n   = bus.data_gen_num_in;
          cnt_n   = '0;
          acc_n   = START_VALUE;
        end
      end
      RUN: begin
        // acc carries START_VALUE + cnt*STEP, wrapping naturally at DATA_WIDTH
        vld_n  = 1'b1;
        data_n = acc;
        acc_n  = acc + STEP;
        cnt_n  = cnt + 9'd1;
        if (cnt == {1'b0, num_q}) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data_gen_o       = data_q;
  assign bus.data_gen_valid_o = vld_q;

endmodule

// File: tb/tb_burst_data_gen.sv
// Directed bench for burst_data_gen: reset, burst length/content, retrigger, wrap, mid-burst reset.
module tb_burst_data_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_data_gen_if #(.DATA_WIDTH(8)) if_a ();
  burst_data_gen_if #(.DATA_WIDTH(8)) if_b ();

  burst_data_gen u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  burst_data_gen #(.START_VALUE(8'hFE)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] qa_dat[$];
  int         qa_cyc[$];
  logic [7:0] qb_dat[$];
  int         qb_cyc[$];

  // Logs every valid word with the index of the edge that produced it
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (if_a.data_gen_valid_o === 1'b1) begin
      qa_dat.push_back(if_a.data_gen_o);
      qa_cyc.push_back(cyc);
    end
    if (if_b.data_gen_valid_o === 1'b1) begin
      qb_dat.push_back(if_b.data_gen_o);
      qb_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_a.data_gen_in = 1'b0; if_a.data_gen_num_in = 8'd0;
    if_b.data_gen_in = 1'b0; if_b.data_gen_num_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if_a.data_gen_in = ~if_a.data_gen_in;
      if_b.data_gen_in = ~if_b.data_gen_in;
      checks++;
      if (if_a.data_gen_valid_o !== 1'b0 || if_a.data_gen_o !== 8'h00) begin
        failures++;
        $display("FAIL reset_a[%0d]: valid=%b data=%h expected valid=0 data=00", i, if_a.data_gen_valid_o, if_a.data_gen_o);
      end
      checks++;
      if (if_b.data_gen_valid_o !== 1'b0 || if_b.data_gen_o !== 8'h00) begin
        failures++;
        $display("FAIL reset_b[%0d]: valid=%b data=%h expected valid=0 data=00", i, if_b.data_gen_valid_o, if_b.data_gen_o);
      end
    end
    // Trigger is high across reset release: must not count as an edge
    rst_n = 1'b1;
    step(6);
    checks++;
    if (qa_dat.size() !== 0) begin
      failures++;
      $display("FAIL reset_release_held_trigger_a: words=%0d expected 0", qa_dat.size());
    end
    checks++;
    if (qb_dat.size() !== 0) begin
      failures++;
      $display("FAIL reset_release_held_trigger_b: words=%0d expected 0", qb_dat.size());
    end
    if_a.data_gen_in = 1'b0;
    if_b.data_gen_in = 1'b0;
    step(2);
  endtask

  task automatic test_burst_n15();
    int c0;
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_num_in = 8'd15;
    if_a.data_gen_in = 1'b1;
    c0 = cyc;
    step(1);
    checks++;
    if (if_a.data_gen_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL n15_no_early_valid: valid=%b expected 0", if_a.data_gen_valid_o);
    end
    if_a.data_gen_num_in = 8'd2;
    step(1);
    if_a.data_gen_in = 1'b0;
    checks++;
    if (if_a.data_gen_valid_o !== 1'b1 || if_a.data_gen_o !== 8'h00) begin
      failures++;
      $display("FAIL n15_first_word: valid=%b data=%h expected valid=1 data=00", if_a.data_gen_valid_o, if_a.data_gen_o);
    end
    step(20);
    checks++;
    if (qa_dat.size() !== 16) begin
      failures++;
      $display("FAIL n15_len: words=%0d expected 16", qa_dat.size());
    end
    for (int i = 0; i < 16 && i < qa_dat.size(); i++) begin
      checks++;
      if (qa_dat[i] !== 8'(i) || qa_cyc[i] !== c0 + 2 + i) begin
        failures++;
        $display("FAIL n15_word[%0d]: data=%h cycle=%0d expected data=%h cycle=%0d", i, qa_dat[i], qa_cyc[i], 8'(i), c0 + 2 + i);
      end
    end
    checks++;
    if (if_a.data_gen_valid_o !== 1'b0 || if_a.data_gen_o !== 8'h00) begin
      failures++;
      $display("FAIL n15_idle_after: valid=%b data=%h expected valid=0 data=00", if_a.data_gen_valid_o, if_a.data_gen_o);
    end
  endtask

  task automatic test_burst_n0();
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_num_in = 8'd0;
    if_a.data_gen_in = 1'b1;
    step(1);
    if_a.data_gen_in = 1'b0;
    step(6);
    checks++;
    if (qa_dat.size() !== 1 || qa_dat[0] !== 8'h00) begin
      failures++;
      $display("FAIL n0_pulse: words=%0d first=%h expected words=1 first=00", qa_dat.size(), (qa_dat.size() > 0) ? qa_dat[0] : 8'hxx);
    end
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_in = 1'b1;
    step(10);
    if_a.data_gen_in = 1'b0;
    step(4);
    checks++;
    if (qa_dat.size() !== 1 || qa_dat[0] !== 8'h00) begin
      failures++;
      $display("FAIL n0_held: words=%0d first=%h expected words=1 first=00", qa_dat.size(), (qa_dat.size() > 0) ? qa_dat[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int exp_cyc;
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_num_in = 8'd3;
    if_a.data_gen_in = 1'b1;
    c0 = cyc;
    step(1);
    if_a.data_gen_in = 1'b0;
    step(1);
    if_a.data_gen_in = 1'b1;   // edge lands mid-burst: ignored
    step(2);
    if_a.data_gen_in = 1'b0;
    step(1);
    if_a.data_gen_in = 1'b1;   // edge lands as the FSM returns to idle: accepted
    step(1);
    if_a.data_gen_in = 1'b0;
    step(10);
    checks++;
    if (qa_dat.size() !== 8) begin
      failures++;
      $display("FAIL b2b_len: words=%0d expected 8", qa_dat.size());
    end
    for (int i = 0; i < 8 && i < qa_dat.size(); i++) begin
      exp_cyc = (i < 4) ? c0 + 2 + i : c0 + 3 + i;
      checks++;
      if (qa_dat[i] !== 8'(i % 4) || qa_cyc[i] !== exp_cyc) begin
        failures++;
        $display("FAIL b2b_word[%0d]: data=%h cycle=%0d expected data=%h cycle=%0d", i, qa_dat[i], qa_cyc[i], 8'(i % 4), exp_cyc);
      end
    end
  endtask

  task automatic test_wrap_and_max();
    logic [7:0] exp_b [4];
    exp_b = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    qb_dat.delete(); qb_cyc.delete();
    if_b.data_gen_num_in = 8'd3;
    if_b.data_gen_in = 1'b1;
    step(1);
    if_b.data_gen_in = 1'b0;
    step(8);
    checks++;
    if (qb_dat.size() !== 4) begin
      failures++;
      $display("FAIL wrap_len: words=%0d expected 4", qb_dat.size());
    end
    for (int i = 0; i < 4 && i < qb_dat.size(); i++) begin
      checks++;
      if (qb_dat[i] !== exp_b[i]) begin
        failures++;
        $display("FAIL wrap_word[%0d]: data=%h expected %h", i, qb_dat[i], exp_b[i]);
      end
    end

    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_num_in = 8'd255;
    if_a.data_gen_in = 1'b1;
    step(1);
    if_a.data_gen_in = 1'b0;
    step(270);
    checks++;
    if (qa_dat.size() !== 256) begin
      failures++;
      $display("FAIL n255_len: words=%0d expected 256", qa_dat.size());
    end
    if (qa_dat.size() == 256) begin
      checks++;
      if (qa_cyc[255] - qa_cyc[0] !== 255) begin
        failures++;
        $display("FAIL n255_contiguous: span=%0d expected 255", qa_cyc[255] - qa_cyc[0]);
      end
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (qa_dat[i] !== 8'(i)) begin
          failures++;
          $display("FAIL n255_word[%0d]: data=%h expected %h", i, qa_dat[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_num_in = 8'd15;
    if_a.data_gen_in = 1'b1;
    step(1);
    if_a.data_gen_in = 1'b0;
    k = 0;
    while (qa_dat.size() < 6 && k < 30) begin
      step(1);
      k++;
    end
    checks++;
    if (qa_dat.size() !== 6 || if_a.data_gen_o !== 8'h05) begin
      failures++;
      $display("FAIL midrst_reach_word5: words=%0d data=%h expected words=6 data=05", qa_dat.size(), if_a.data_gen_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_a.data_gen_valid_o !== 1'b0 || if_a.data_gen_o !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async_clear: valid=%b data=%h expected valid=0 data=00", if_a.data_gen_valid_o, if_a.data_gen_o);
    end
    step(2);
    rst_n = 1'b1;
    step(20);
    checks++;
    if (qa_dat.size() !== 6) begin
      failures++;
      $display("FAIL midrst_no_resume: words=%0d expected 6", qa_dat.size());
    end
    qa_dat.delete(); qa_cyc.delete();
    if_a.data_gen_in = 1'b1;
    step(1);
    if_a.data_gen_in = 1'b0;
    step(20);
    checks++;
    if (qa_dat.size() !== 16 || qa_dat[0] !== 8'h00 || qa_dat[15] !== 8'h0F) begin
      failures++;
      $display("FAIL midrst_fresh_burst: words=%0d expected 16 words 00..0F", qa_dat.size());
    end
  endtask

  initial begin
    test_reset();
    test_burst_n15();
    test_burst_n0();
    test_back_to_back();
    test_wrap_and_max();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
